// File: rtl/l2_cacheline_adaptor_pkg.sv
// ----------------------------------------------------------------------------
// l2_cacheline_adaptor_pkg
//   Shared types and sizes for the L2 <-> physical-memory line adaptor.
//   Line is 256 bits. A memory beat is 64 bits, so one line is 4 beats.
//   The line address is aligned to 32 bytes.
// ----------------------------------------------------------------------------
package l2_cacheline_adaptor_pkg;

    localparam int S_LINE      = 256;
    localparam int S_BURST     = 64;
    localparam int S_OFFSET    = 5;
    localparam int LLC_BEATS   = S_LINE / S_BURST;
    localparam int TIMEOUT_CYC = 1024;

    typedef logic [S_BURST-1:0] llc_burst_t;
    typedef logic [S_LINE-1:0]  llc_cacheline_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    // Clear the byte-offset bits so memory always sees the line base address.
    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:S_OFFSET], {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_cacheline_adaptor.sv
// ----------------------------------------------------------------------------
// l2_cacheline_adaptor
//   Sits between the L2 pmem port and physical memory. A single 256-bit line
//   transfer is split into four 64-bit beats. On a fill, read beats are
//   reassembled into a 256-bit line. Only one transaction is in flight at a
//   time. The L2 holds its request until it sees resp_o.
//
//   Ports
//     clk, rst       clock; synchronous active-high reset
//     line_i         writeback line from L2
//     line_o         assembled fill line to L2 (holds until the next fill)
//     address_i      line address from L2
//     read_i/write_i L2 fill / writeback request, held until resp_o
//     resp_o         one-cycle completion pulse to L2
//     burst_i        read beat from memory
//     burst_o        write beat to memory
//     address_o      registered line-aligned address to memory
//     read_o/write_o memory read / write request
//     resp_i         memory beat strobe (one per beat, gaps allowed)
//     timeout_o      sticky watchdog flag
//
//   Configuration
//     L2_ADAPTOR_TIMEOUT_EN  enables a watchdog. When a burst stalls for
//                            TIMEOUT_CYC cycles, the watchdog forces
//                            completion and sets timeout_o. Without the
//                            macro, timeout_o is tied 0 and the block waits
//                            indefinitely.
// ----------------------------------------------------------------------------
module l2_cacheline_adaptor
    import l2_cacheline_adaptor_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [255:0]  line_i,
    output logic [255:0]  line_o,
    input  logic [31:0]   address_i,
    input  logic          read_i,
    input  logic          write_i,
    output logic          resp_o,
    input  logic [63:0]   burst_i,
    output logic [63:0]   burst_o,
    output logic [31:0]   address_o,
    output logic          read_o,
    output logic          write_o,
    input  logic          resp_i,
    output logic          timeout_o
);

    adaptor_state_t                 r_state;
    logic [1:0]                     r_cnt;
    llc_burst_t [LLC_BEATS-1:0]     r_line;   // fill line, indexed by beat
    llc_burst_t [LLC_BEATS-1:0]     r_wbuf;   // latched writeback line
    llc_burst_t                     r_burst;
    logic [31:0]                    r_addr;
    logic                           r_read;
    logic                           r_write;
    logic                           r_resp;
    logic                           w_last;
    logic                           w_wdog_fire;

    assign w_last = (r_cnt == 2'(LLC_BEATS - 1));

`ifdef L2_ADAPTOR_TIMEOUT_EN
    logic [9:0] r_wdog;
    logic       r_timeout;

    // The watchdog restarts on every beat and on burst entry. It fires on
    // the TIMEOUT_CYC-th consecutive cycle without a beat.
    assign w_wdog_fire = (r_state == READ || r_state == WRITE) && !resp_i &&
                         (r_wdog == 10'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if ((r_state == READ || r_state == WRITE) && !resp_i)
                r_wdog <= r_wdog + 10'd1;
            else
                r_wdog <= '0;
            if (w_wdog_fire)
                r_timeout <= 1'b1;
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_wdog_fire = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
            r_wbuf  <= '0;
            r_burst <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    // On a simultaneous request, the writeback goes first.
                    // The L2 keeps read_i high, and the read is taken on a
                    // later IDLE cycle.
                    if (write_i) begin
                        r_wbuf  <= line_i;
                        r_burst <= line_i[63:0];
                        r_addr  <= line_addr(address_i);
                        r_cnt   <= '0;
                        r_write <= 1'b1;
                        r_state <= WRITE;
                    end else if (read_i) begin
                        r_addr  <= line_addr(address_i);
                        r_cnt   <= '0;
                        r_read  <= 1'b1;
                        r_state <= READ;
                    end
                end
                READ: begin
                    if (resp_i) begin
                        r_line[r_cnt] <= burst_i;
                        r_cnt         <= r_cnt + 2'd1;
                        if (w_last) begin
                            r_read  <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else if (w_wdog_fire) begin
                        r_read  <= 1'b0;
                        r_resp  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end
                WRITE: begin
                    if (resp_i) begin
                        // Preload the next beat so burst_o is valid for the
                        // next strobe.
                        r_burst <= r_wbuf[r_cnt + 2'd1];
                        r_cnt   <= r_cnt + 2'd1;
                        if (w_last) begin
                            r_write <= 1'b0;
                            r_resp  <= 1'b1;
                            r_state <= DONE;
                        end
                    end else if (w_wdog_fire) begin
                        r_write <= 1'b0;
                        r_resp  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // resp_o is high only in this state. The following IDLE
                    // cycle lets the L2 drop a request that has already been
                    // serviced.
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign line_o    = r_line;
    assign burst_o   = r_burst;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;

endmodule

// File: tb/tb_l2_cacheline_adaptor.sv
module tb_l2_cacheline_adaptor;

    logic          clk = 1'b0;
    logic          rst;
    logic [255:0]  line_i;
    logic [255:0]  line_o;
    logic [31:0]   address_i;
    logic          read_i;
    logic          write_i;
    logic          resp_o;
    logic [63:0]   burst_i;
    logic [63:0]   burst_o;
    logic [31:0]   address_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i;
    logic          timeout_o;

    l2_cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_rd;
        logic [255:0] line;
    } txn_t;

    txn_t         exp_q[$];
    logic [63:0]  beat_q[$];
    int           n_tot = 0;
    int           n_bad = 0;
    int           n_resp = 0;
    int           n_txn = 0;
    logic [255:0] last_line = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor. Outputs are sampled on the falling edge, away from
    // the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (write_o && resp_i) begin
                if (beat_q.size() == 0) chk("wr_beat_unexp", 1, 0);
                else chk("wr_beat", burst_o, beat_q.pop_front());
            end
            if (resp_o) begin
                n_resp++;
                if (exp_q.size() == 0) chk("resp_unexp", 1, 0);
                else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    if (t.is_rd) chk("fill_line", line_o, t.line);
                end
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input logic [255:0] ln,
                           input logic [7:0] pat, input int plen, input int exp_lat);
        int n;
        int idx;
        int p;
        address_i = a;
        read_i    = 1'b1;
        exp_q.push_back('{1'b1, ln});
        n_txn++;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!read_o && n < 40);
        chk("rd_lat", n, exp_lat);
        chk("rd_addr", address_o, {a[31:5], 5'b0});
        idx = 0;
        p   = 0;
        while (idx < 4 && p < 64) begin
            resp_i  = pat[p % plen];
            burst_i = resp_i ? ln[idx*64 +: 64] : {$urandom, $urandom};
            if (!resp_i) chk("rd_hold", read_o, 1);
            @(posedge clk); #1;
            if (resp_i) idx++;
            p++;
        end
        resp_i = 1'b0;
        chk("rd_resp", resp_o, 1);
        chk("rd_drop", read_o, 0);
        @(posedge clk); #1;
        read_i = 1'b0;
        chk("rd_pulse", resp_o, 0);
        chk("rd_idle", read_o, 0);
        last_line = ln;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] ln,
                            input logic [7:0] pat, input int plen, input logic with_rd);
        int n;
        int idx;
        int p;
        address_i = a;
        line_i    = ln;
        write_i   = 1'b1;
        read_i    = with_rd;
        for (int k = 0; k < 4; k++) beat_q.push_back(ln[k*64 +: 64]);
        exp_q.push_back('{1'b0, ln});
        n_txn++;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!write_o && n < 40);
        chk("wr_lat", n, 1);
        chk("wr_addr", address_o, {a[31:5], 5'b0});
        chk("wr_noread", read_o, 0);
        line_i = {8{$urandom}};   // the block must have latched the line already
        idx = 0;
        p   = 0;
        while (idx < 4 && p < 64) begin
            resp_i = pat[p % plen];
            chk("wr_hold", write_o, 1);
            @(posedge clk); #1;
            if (resp_i) idx++;
            p++;
        end
        resp_i = 1'b0;
        chk("wr_resp", resp_o, 1);
        chk("wr_drop", write_o, 0);
        @(posedge clk); #1;
        write_i = 1'b0;
        chk("wr_pulse", resp_o, 0);
        chk("wr_idle", write_o, 0);
        chk("wr_noacc", read_o, 0);
    endtask

    initial begin
        logic [255:0] l1;
        logic [255:0] l2;
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_line",  line_o, 0);
        chk("rst_burst", burst_o, 0);
        chk("rst_addr",  address_o, 0);
        chk("rst_rd",    read_o, 0);
        chk("rst_wr",    write_o, 0);
        chk("rst_resp",  resp_o, 0);
        chk("rst_to",    timeout_o, 0);
        rst = 1'b0;

        // A stray strobe in IDLE must not do anything.
        resp_i = 1'b1; burst_i = 64'hdead_beef_dead_beef;
        @(posedge clk); #1;
        resp_i = 1'b0;
        chk("idle_stray", line_o, 0);

        // Basic fill: beats back to back, and the address offset is cleared.
        l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        do_read(32'h8000_0013, l1, 8'h01, 1, 1);
        chk("line_hold", line_o, l1);

        // Basic writeback: D0 first.
        l2 = {64'hd3d3_0003_0003_d3d3, 64'hd2d2_0002_0002_d2d2,
              64'hd1d1_0001_0001_d1d1, 64'hd0d0_0000_0000_d0d0};
        do_write(32'h1234_567f, l2, 8'h01, 1, 1'b0);
        chk("line_kept", line_o, l1);

        // Strobe gaps 1,0,0,1,1,0,1 on both directions.
        do_read(32'h0000_1040, {$urandom, $urandom, $urandom, $urandom,
                                $urandom, $urandom, $urandom, $urandom},
                8'b1011_001, 7, 1);
        do_write(32'h0000_2020, {8{$urandom}}, 8'b1011_001, 7, 1'b0);

        // Simultaneous read and write: the write goes first, and the read
        // starts after one IDLE cycle.
        do_write(32'hcafe_0000, {8{$urandom}}, 8'h01, 1, 1'b1);
        do_read(32'hcafe_0020, {8{$urandom}}, 8'b101, 3, 1);

        // Reset in the middle of a fill.
        address_i = 32'h5555_5555; read_i = 1'b1;
        @(posedge clk); #1;
        chk("ab_req", read_o, 1);
        resp_i = 1'b1;
        repeat (2) begin burst_i = {$urandom, $urandom}; @(posedge clk); #1; end
        rst = 1'b1; burst_i = {$urandom, $urandom};
        @(posedge clk); #1;
        rst = 1'b0; read_i = 1'b0;
        chk("ab_rd",   read_o, 0);
        chk("ab_line", line_o, 0);
        chk("ab_addr", address_o, 0);
        repeat (3) begin burst_i = {$urandom, $urandom}; @(posedge clk); #1; end
        resp_i = 1'b0;
        chk("ab_stray_rd",   read_o, 0);
        chk("ab_stray_line", line_o, 0);
        chk("ab_stray_resp", resp_o, 0);
        do_read(32'h0bad_f00d, {8{$urandom}}, 8'b0110, 4, 1);

`ifdef L2_ADAPTOR_TIMEOUT_EN
        begin
            int n;
            address_i = 32'h7000_0000; read_i = 1'b1;
            exp_q.push_back('{1'b1, last_line});
            n_txn++;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!resp_o && n < 1200);
            chk("to_resp", resp_o, 1);
            chk("to_flag", timeout_o, 1);
            chk("to_rd",   read_o, 0);
            @(posedge clk); #1;
            read_i = 1'b0;
            chk("to_sticky", timeout_o, 1);
        end
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        chk("beat_drain", beat_q.size(), 0);
        chk("resp_count", n_resp, n_txn);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
